bcd_scan_counter: RTL and testbench

BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

---
 rtl/bcd_scan_counter.sv | 185 ++++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// BCD up/down counter with load, clamped load digits, wrap pulse and a
// multiplexed active-low 7-segment scanner with optional leading-zero blanking.
module bcd_scan_counter #(
   parameter int unsigned DIGITS   = 4,
   parameter int unsigned TICK_DIV = 6_250_000,
   parameter int unsigned SCAN_DIV = 12_500
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  up,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  blank_lz,
   output logic [7:0]            segmentos,
   output logic [DIGITS-1:0]     sel_seg,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  wrap
);

   localparam int unsigned BCD_W  = 4 * DIGITS;
   localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

   logic [TICK_W-1:0] tick_cnt;
   logic [SCAN_W-1:0] scan_cnt;
   logic [IDX_W-1:0]  idx;

   logic              tick_c;
   logic              slot_end_c;
   logic              step_c;
   logic [BCD_W-1:0]  bcd_step_c;
   logic              carry_c;
   logic [BCD_W-1:0]  bcd_load_c;
   logic [DIGITS-1:0] lz_c;
   logic [3:0]        digit_c;
   logic              blank_c;
   logic [DIGITS-1:0] sel_c;

   // Active-low 7-segment pattern, dp off.
   function automatic logic [7:0] seg7(input logic [3:0] d);
      logic [7:0] s;
      case (d)
         4'd0:    s = 8'hC0;
         4'd1:    s = 8'hF9;
         4'd2:    s = 8'hA4;
         4'd3:    s = 8'hB0;
         4'd4:    s = 8'h99;
         4'd5:    s = 8'h92;
         4'd6:    s = 8'h82;
         4'd7:    s = 8'hF8;
         4'd8:    s = 8'h80;
         4'd9:    s = 8'h90;
         default: s = 8'hFF;
      endcase
      return s;
   endfunction

   assign tick_c     = (tick_cnt == TICK_LAST);
   assign slot_end_c = (scan_cnt == SCAN_LAST);
   assign step_c     = tick_c && en && !load;

   // Cascaded decimal increment/decrement; carry out of the top digit is the wrap.
   always_comb begin : p_step
      logic       carry;
      logic [3:0] d;
      bcd_step_c = bcd_out;
      carry      = 1'b1;
      d          = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         d = bcd_out[4*k +: 4];
         if (carry) begin
            if (up) begin
               if (d >= 4'd9) begin
                  bcd_step_c[4*k +: 4] = 4'd0;
               end else begin
                  bcd_step_c[4*k +: 4] = d + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (d == 4'd0) begin
                  bcd_step_c[4*k +: 4] = 4'd9;
               end else begin
                  bcd_step_c[4*k +: 4] = d - 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
      carry_c = carry;
   end

   // Load value with every out-of-range digit clamped to 9.
   always_comb begin : p_clamp
      logic [3:0] d;
      bcd_load_c = '0;
      d          = 4'd0;
      for (int k = 0; k < DIGITS; k++) begin
         d = load_val[4*k +: 4];
         bcd_load_c[4*k +: 4] = (d > 4'd9) ? 4'd9 : d;
      end
   end

   // lz_c[k] is set when digits k..DIGITS-1 are all zero.
   always_comb begin : p_lz
      logic run;
      lz_c = '0;
      run  = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         run     = run && (bcd_out[4*k +: 4] == 4'd0);
         lz_c[k] = run;
      end
   end

   // Pick the digit under scan, its select line and its blanking state.
   always_comb begin : p_pick
      digit_c = 4'd0;
      blank_c = 1'b0;
      sel_c   = '1;
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IDX_W'(k)) begin
            digit_c  = bcd_out[4*k +: 4];
            blank_c  = blank_lz && (k != 0) && lz_c[k];
            sel_c[k] = 1'b0;
         end
      end
   end

   // Tick divider; a load restarts the count period.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (load || tick_c) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
      end
   end

   // Count register and wrap pulse; load wins over a coincident tick.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcd_out <= '0;
         wrap    <= 1'b0;
      end else begin
         wrap <= 1'b0;
         if (load) begin
            bcd_out <= bcd_load_c;
         end else if (step_c) begin
            bcd_out <= bcd_step_c;
            wrap    <= carry_c;
         end
      end
   end

   // Scan divider and digit index.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (slot_end_c) begin
         scan_cnt <= '0;
         idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
      end else begin
         scan_cnt <= scan_cnt + SCAN_W'(1);
      end
   end

   // Registered display drive sampled from the live count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         segmentos <= 8'hFF;
         sel_seg   <= '1;
      end else begin
         segmentos <= blank_c ? 8'hFF : seg7(digit_c);
         sel_seg   <= sel_c;
      end
   end

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Directed bench for bcd_scan_counter with DIGITS=3, TICK_DIV=4, SCAN_DIV=2.
module tb_bcd_scan_counter;

   localparam int unsigned DIGITS   = 3;
   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned SCAN_DIV = 2;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic        en       = 1'b0;
   logic        up       = 1'b1;
   logic        load     = 1'b0;
   logic [11:0] load_val = 12'h000;
   logic        blank_lz = 1'b0;
   logic [7:0]  segmentos;
   logic [2:0]  sel_seg;
   logic [11:0] bcd_out;
   logic        wrap;

   int n_checks = 0;
   int n_errors = 0;

   bcd_scan_counter #(
      .DIGITS   (DIGITS),
      .TICK_DIV (TICK_DIV),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .up        (up),
      .load      (load),
      .load_val  (load_val),
      .blank_lz  (blank_lz),
      .segmentos (segmentos),
      .sel_seg   (sel_seg),
      .bcd_out   (bcd_out),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_load(input logic [11:0] v);
      load     = 1'b1;
      load_val = v;
      step(1);
      load     = 1'b0;
   endtask

   function automatic logic [11:0] to_bcd(input int v);
      return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bcd"}, bcd_out, 12'h000);
      check({tag, "_wrap"}, wrap, 1'b0);
      check({tag, "_seg"}, segmentos, 8'hFF);
      check({tag, "_sel"}, sel_seg, 3'b111);
   endtask

   // Watch six consecutive cycles of the scan at count 0x007.
   task automatic scan_check(input logic blank);
      logic [2:0] seen;
      logic [2:0] prev;
      logic [7:0] exp_seg;
      seen = 3'b000;
      prev = sel_seg;
      for (int cyc = 0; cyc < 6; cyc++) begin
         if (cyc > 0) step(1);
         case (sel_seg)
            3'b110:          exp_seg = 8'hF8;
            3'b101, 3'b011:  exp_seg = blank ? 8'hFF : 8'hC0;
            default: begin
               exp_seg = 8'hFF;
               check("sel_onehot", sel_seg, 3'b110);
            end
         endcase
         check(blank ? "seg_blank" : "seg_noblank", segmentos, exp_seg);
         if (cyc > 0 && sel_seg != prev)
            check("scan_order", sel_seg, {prev[1:0], prev[2]});
         seen = seen | ~sel_seg;
         prev = sel_seg;
      end
      check("scan_all_digits", seen, 3'b111);
   endtask

   initial begin
      logic wrap_seen;

      // Reset asserted before any clock edge.
      #1 rst = 1'b1;
      #2;
      check_reset_outputs("rst_async");
      step(2);
      rst = 1'b0;
      en  = 1'b1;
      up  = 1'b1;

      // Twelve up ticks, one step per four cycles.
      wrap_seen = 1'b0;
      for (int i = 1; i <= 12; i++) begin
         for (int c = 1; c <= 4; c++) begin
            step(1);
            if (wrap) wrap_seen = 1'b1;
            if (c == 3) check("count_hold", bcd_out, to_bcd(i - 1));
         end
         check("count_up", bcd_out, to_bcd(i));
      end
      check("count_012", bcd_out, 12'h012);
      check("no_wrap_up", wrap_seen, 1'b0);

      // 998 -> 999 -> 000 with a single wrap cycle.
      do_load(12'h998);
      check("load_998", bcd_out, 12'h998);
      check("load_no_wrap", wrap, 1'b0);
      wrap_seen = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         step(1);
         if (wrap) wrap_seen = 1'b1;
      end
      check("up_999", bcd_out, 12'h999);
      check("no_wrap_999", wrap_seen, 1'b0);
      step(3);
      check("hold_999", bcd_out, 12'h999);
      check("no_wrap_pre", wrap, 1'b0);
      step(1);
      check("wrap_000", bcd_out, 12'h000);
      check("wrap_up_hi", wrap, 1'b1);
      step(1);
      check("wrap_up_lo", wrap, 1'b0);

      // Down from 000 wraps to 999; clamped load.
      up = 1'b0;
      do_load(12'h000);
      check("load_000", bcd_out, 12'h000);
      step(3);
      check("down_hold", bcd_out, 12'h000);
      check("down_no_wrap", wrap, 1'b0);
      step(1);
      check("down_999", bcd_out, 12'h999);
      check("wrap_dn_hi", wrap, 1'b1);
      step(1);
      check("wrap_dn_lo", wrap, 1'b0);
      do_load(12'h0F5);
      check("load_clamp", bcd_out, 12'h095);

      // Display scan at 0x007 with and without leading-zero blanking.
      en       = 1'b0;
      blank_lz = 1'b1;
      do_load(12'h007);
      step(1);
      scan_check(1'b1);
      blank_lz = 1'b0;
      step(1);
      scan_check(1'b0);

      // Load coincident with a tick: load wins, tick period restarts.
      en = 1'b1;
      up = 1'b1;
      do_load(12'h123);
      step(3);
      check("pre_coincide", bcd_out, 12'h123);
      do_load(12'h500);
      check("coincide_load", bcd_out, 12'h500);
      check("coincide_wrap", wrap, 1'b0);
      step(3);
      check("coincide_hold", bcd_out, 12'h500);
      step(1);
      check("coincide_next", bcd_out, 12'h501);

      // Reset mid-count, then restart from zero.
      do_load(12'h456);
      step(2);
      check("pre_rst", bcd_out, 12'h456);
      rst = 1'b1;
      #2;
      check_reset_outputs("rst_mid");
      #2;
      rst = 1'b0;
      step(3);
      check("restart_hold", bcd_out, 12'h000);
      check("restart_wrap", wrap, 1'b0);
      step(1);
      check("restart_001", bcd_out, 12'h001);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
